serial_adder_d: RTL



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder_d.sv | 21 ++
 rtl/serial_adder_d.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and gate delay.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Nominal delay of one 2-input primitive gate, in ns.
    localparam int D = 1;

endpackage

// File: rtl/full_adder_d.sv
// Structural full adder from 2-input AND/OR/XOR primitives.
// Carry path is xor -> and -> or, three gate delays deep.
module full_adder_d (
    output logic s,
    output logic co,
    input  logic x,
    input  logic y,
    input  logic ci
);

    logic p;
    logic g;
    logic t;

    assign p  = x ^ y;
    assign g  = x & y;
    assign t  = p & ci;
    assign s  = p ^ ci;
    assign co = g | t;

endmodule

// File: rtl/serial_adder_d.sv
// Bit-serial adder: one full adder time-shared over WIDTH cycles, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder_d
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             fa_s, fa_co;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    full_adder_d u_fa (
        .s  (fa_s),
        .co (fa_co),
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_c;

    // Overflow = carry into MSB xor carry out of MSB, seen on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_c <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == S_SHIFT && last) ovf_c <= carry ^ fa_co;
            if (state == S_DONE)          ovf   <= ovf_c;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    // Hold at WIDTH-1 so the counter never wraps.
                    if (!last) cnt <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    sum  <= sum_sr;
                    cout <= carry;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
